lanzones_imem_responder: RTL and testbench

- Instruction-memory responder sitting on the far end of the lanzones core fetch interface (RRdy/RAddr out of the core, RVld/RData/LEn into the core).
- Holds a word-addressed program store, preloaded through a simple write port while the core is held off.
- After the load completes, it raises LEn and serves each core fetch request with a single-cycle RVld pulse after a programmable latency.

---
 rtl/lanzones_imem_responder.sv | 95 +++++++++
 tb/tb_lanzones_imem_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/lanzones_imem_responder.sv
// Instruction-memory responder for the lanzones core fetch port: preloadable
// word store, then one registered RVld pulse per RRdy request after LATENCY cycles.
module lanzones_imem_responder #(
  parameter int          AW       = 8,
  parameter int          LATENCY  = 2,
  parameter logic [31:0] OOB_DATA = 32'h00000013
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          RRdy,
  input  logic [31:0]   RAddr,
  output logic          RVld,
  output logic [31:0]   RData,
  output logic          LEn,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          ld_done,
  output logic          oob_err
);

  // state | meaning
  // IDLE  | waiting for RRdy with LEn=1
  // WAIT  | counting down the remaining latency
  // RESP  | RVld/RData are registered at the end of this cycle
  // DRAIN | response issued, waiting for the core to drop RRdy
  typedef enum logic [1:0] {IDLE, WAIT, RESP, DRAIN} state_t;

  // RVld is registered from RESP, so WAIT absorbs LATENCY-2 extra cycles.
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [32:0] DEPTH   = 33'd1 << AW;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic        accept;
  logic        addr_oob;
  logic [31:0] mem [0:(2**AW)-1];

  assign addr_oob = ({1'b0, addr_q} >= DEPTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (LEn && RRdy) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = DRAIN;
      DRAIN:   if (!RRdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      RVld    <= 1'b0;
      RData   <= 32'd0;
      LEn     <= 1'b0;
      oob_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) addr_q <= RAddr;
      RVld <= (state_q == RESP);
      if (state_q == RESP) begin
        if (addr_oob) begin
          RData   <= OOB_DATA;
          oob_err <= 1'b1;
        end else begin
          RData <= mem[addr_q[AW-1:0]];
        end
      end
      if (ld_done) LEn <= 1'b1;
    end
  end

  // Store has no reset so a program survives a mid-run reset.
  always_ff @(posedge clk) begin
    if (ld_we && !LEn) mem[ld_addr] <= ld_data;
  end

endmodule

// File: tb/tb_lanzones_imem_responder.sv
// Bench for lanzones_imem_responder: LATENCY=2 instance (a) and LATENCY=1 instance (b)
// sharing the preload port, with table-driven fetches and hand-written corner sequences.
module tb_lanzones_imem_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ld_we, ld_done;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  logic        rrdy_a, rrdy_b;
  logic [31:0] raddr_a, raddr_b;
  logic        rvld_a, rvld_b, len_a, len_b, oob_a, oob_b;
  logic [31:0] rdata_a, rdata_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lanzones_imem_responder #(.AW(8), .LATENCY(2), .OOB_DATA(32'h00000013)) dut_a (
    .clk(clk), .rstn(rstn), .RRdy(rrdy_a), .RAddr(raddr_a), .RVld(rvld_a),
    .RData(rdata_a), .LEn(len_a), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_done(ld_done), .oob_err(oob_a));

  lanzones_imem_responder #(.AW(8), .LATENCY(1), .OOB_DATA(32'h00000013)) dut_b (
    .clk(clk), .rstn(rstn), .RRdy(rrdy_b), .RAddr(raddr_b), .RVld(rvld_b),
    .RData(rdata_b), .LEn(len_b), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_done(ld_done), .oob_err(oob_b));

  typedef struct {
    bit          sel_b;
    logic [31:0] addr;
    bit          hold;
    logic [31:0] exp_data;
    bit          exp_oob;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic pulse_done();
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
  endtask

  // Issues one request at a negedge; the accepting edge is k=1, so RVld is
  // expected at k = LATENCY+1. Core drops RRdy after RVld unless hold is set.
  task automatic run_vec(input vec_t v, input string tag);
    int first_k, pulses, exp_k;
    logic [31:0] data;
    logic rv;
    first_k = 0; pulses = 0; data = 32'h0;
    exp_k = v.sel_b ? 2 : 3;
    if (v.sel_b) begin rrdy_b = 1'b1; raddr_b = v.addr; end
    else         begin rrdy_a = 1'b1; raddr_a = v.addr; end
    for (int k = 1; k <= 12; k++) begin
      tick();
      rv = v.sel_b ? rvld_b : rvld_a;
      if (rv) begin
        pulses++;
        if (first_k == 0) begin
          first_k = k;
          data = v.sel_b ? rdata_b : rdata_a;
        end
      end
      if ((rv && !v.hold) || (v.hold && k == 10)) begin
        if (v.sel_b) rrdy_b = 1'b0; else rrdy_a = 1'b0;
      end
    end
    if (first_k == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: no RVld within 12 cycles", tag);
    end else begin
      chk({tag, "_latency"}, 32'(first_k), 32'(exp_k));
      chk({tag, "_data"}, data, v.exp_data);
    end
    chk({tag, "_pulses"}, 32'(pulses), 32'd1);
    chk({tag, "_oob"}, 32'(v.sel_b ? oob_b : oob_a), 32'(v.exp_oob));
  endtask

  vec_t vecs[$];
  int   seen;

  initial begin
    rstn = 1'b0; ld_we = 1'b0; ld_done = 1'b0; ld_addr = 8'd0; ld_data = 32'd0;
    rrdy_a = 1'b0; rrdy_b = 1'b0; raddr_a = 32'd0; raddr_b = 32'd0;
    repeat (3) tick();
    chk("rst_rvld_a", 32'(rvld_a), 32'd0);
    chk("rst_len_a", 32'(len_a), 32'd0);
    chk("rst_oob_a", 32'(oob_a), 32'd0);
    chk("rst_rdata_a", rdata_a, 32'd0);
    chk("rst_rvld_b", 32'(rvld_b), 32'd0);
    chk("rst_len_b", 32'(len_b), 32'd0);
    rstn = 1'b1;

    // RRdy without LEn must never be served
    rrdy_a = 1'b1; rrdy_b = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rvld_a || rvld_b) seen++;
    end
    rrdy_a = 1'b0; rrdy_b = 1'b0;
    chk("noload_rvld", 32'(seen), 32'd0);
    chk("noload_len", 32'({len_a, len_b}), 32'd0);

    preload(8'd0, 32'h123450B7);
    preload(8'd1, 32'h00208133);
    preload(8'd3, 32'h00400213);
    preload(8'd255, 32'hCAFEF00D);
    // write coincident with ld_done still lands
    ld_we = 1'b1; ld_addr = 8'd2; ld_data = 32'h00310193; ld_done = 1'b1;
    chk("len_before_done", 32'(len_a), 32'd0);
    tick();
    ld_we = 1'b0; ld_done = 1'b0;
    chk("len_after_done_a", 32'(len_a), 32'd1);
    chk("len_after_done_b", 32'(len_b), 32'd1);

    preload(8'd0, 32'hDEADBEEF);

    vecs.push_back('{1'b0, 32'd0,          1'b0, 32'h123450B7, 1'b0});
    vecs.push_back('{1'b0, 32'd1,          1'b0, 32'h00208133, 1'b0});
    vecs.push_back('{1'b0, 32'd2,          1'b0, 32'h00310193, 1'b0});
    vecs.push_back('{1'b0, 32'd255,        1'b0, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{1'b0, 32'd0,          1'b0, 32'h123450B7, 1'b0});
    vecs.push_back('{1'b1, 32'd1,          1'b1, 32'h00208133, 1'b0});
    vecs.push_back('{1'b1, 32'd0,          1'b0, 32'h123450B7, 1'b0});
    vecs.push_back('{1'b0, 32'h00000100,   1'b0, 32'h00000013, 1'b1});
    vecs.push_back('{1'b0, 32'd3,          1'b0, 32'h00400213, 1'b1});
    vecs.push_back('{1'b1, 32'h80000001,   1'b0, 32'h00000013, 1'b1});
    vecs.push_back('{1'b1, 32'd1,          1'b0, 32'h00208133, 1'b1});
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // reset while dut_a sits in WAIT kills the request
    rrdy_a = 1'b1; raddr_a = 32'd1;
    tick();
    rstn = 1'b0; rrdy_a = 1'b0;
    tick();
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rvld_a) seen++;
    end
    chk("killed_rvld", 32'(seen), 32'd0);
    chk("killed_len", 32'(len_a), 32'd0);
    chk("killed_oob", 32'(oob_a), 32'd0);
    pulse_done();
    chk("relaunch_len", 32'(len_a), 32'd1);
    run_vec('{1'b0, 32'd0, 1'b0, 32'h123450B7, 1'b0}, "post_rst0");
    run_vec('{1'b0, 32'd255, 1'b0, 32'hCAFEF00D, 1'b0}, "post_rst255");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
